// File: rtl/fr_pe_driver.sv
// Initiator-side sequencer for the fuzzy-rule processing element: holds x/m/v
// operand arrays, streams them through the PE and collects the per-element results.
module fr_pe_driver #(
   parameter int N_IN    = 8,
   parameter int AW      = 4,
   parameter int LATENCY = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic [1:0]         wr_sel,
   input  logic [AW-1:0]      wr_addr,
   input  logic signed [15:0] wr_data,
   input  logic               go,
   output logic               busy,
   output logic               pe_rst,
   output logic               pe_start,
   output logic signed [15:0] pe_x,
   output logic signed [15:0] pe_m,
   output logic signed [15:0] pe_v,
   input  logic signed [15:0] pe_odata,
   input  logic               pe_done,
   output logic               res_valid,
   output logic [AW-1:0]      res_idx,
   output logic signed [15:0] res_data,
   output logic signed [19:0] sum_out,
   output logic               done,
   output logic               err
);
   localparam int IW = $clog2(N_IN);
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {S_IDLE, S_CLR, S_ISSUE, S_DRAIN, S_FIN} state_t;
   state_t state_reg, state_next;

   logic signed [15:0] x_mem [N_IN];
   logic signed [15:0] m_mem [N_IN];
   logic signed [15:0] v_mem [N_IN];

   logic signed [15:0] pe_x_reg, pe_m_reg, pe_v_reg;
   logic [AW-1:0]      iss_cnt_reg;
   logic [CW-1:0]      cap_cnt_reg;
   logic [LATENCY-1:0] vld_pipe_reg;
   logic [AW-1:0]      idx_pipe_reg [LATENCY];
   logic               res_valid_reg;
   logic [AW-1:0]      res_idx_reg;
   logic signed [15:0] res_data_reg;
   logic signed [19:0] sum_reg;
   logic               err_reg;

   logic               wr_ok;
   logic               capture;
   logic               rd_en;
   logic [AW-1:0]      rd_addr;

   assign wr_ok   = wr_en && (state_reg == S_IDLE) && (wr_sel != 2'd3)
                    && ({1'b0, wr_addr} < CW'(N_IN));
   assign capture = vld_pipe_reg[LATENCY-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_IN; i++) begin
            x_mem[i] <= '0;
            m_mem[i] <= '0;
            v_mem[i] <= '0;
         end
      end else if (wr_ok) begin
         case (wr_sel)
            2'd0:    x_mem[wr_addr[IW-1:0]] <= wr_data;
            2'd1:    m_mem[wr_addr[IW-1:0]] <= wr_data;
            2'd2:    v_mem[wr_addr[IW-1:0]] <= wr_data;
            default: ;
         endcase
      end
   end

   // Operands are fetched one cycle ahead so element i sits on pe_* in ISSUE cycle i.
   always_comb begin
      rd_en   = 1'b0;
      rd_addr = '0;
      if (state_reg == S_CLR) begin
         rd_en = 1'b1;
      end else if (state_reg == S_ISSUE && iss_cnt_reg != AW'(N_IN - 1)) begin
         rd_en   = 1'b1;
         rd_addr = iss_cnt_reg + AW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pe_x_reg <= '0;
         pe_m_reg <= '0;
         pe_v_reg <= '0;
      end else if (rd_en) begin
         pe_x_reg <= x_mem[rd_addr[IW-1:0]];
         pe_m_reg <= m_mem[rd_addr[IW-1:0]];
         pe_v_reg <= v_mem[rd_addr[IW-1:0]];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= S_IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      busy       = 1'b1;
      pe_rst     = 1'b0;
      pe_start   = 1'b0;
      done       = 1'b0;
      case (state_reg)
         S_IDLE: begin
            busy = 1'b0;
            if (go) state_next = S_CLR;
         end
         S_CLR: begin
            pe_rst     = 1'b1;
            state_next = S_ISSUE;
         end
         S_ISSUE: begin
            pe_start = 1'b1;
            if (iss_cnt_reg == AW'(N_IN - 1)) state_next = S_DRAIN;
         end
         S_DRAIN: begin
            // Leave on the edge that takes the last capture so done lines up with it.
            if (capture && cap_cnt_reg == CW'(N_IN - 1)) state_next = S_FIN;
         end
         S_FIN: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         iss_cnt_reg   <= '0;
         cap_cnt_reg   <= '0;
         vld_pipe_reg  <= '0;
         for (int i = 0; i < LATENCY; i++) idx_pipe_reg[i] <= '0;
         res_valid_reg <= 1'b0;
         res_idx_reg   <= '0;
         res_data_reg  <= '0;
         sum_reg       <= '0;
         err_reg       <= 1'b0;
      end else if (state_reg == S_CLR) begin
         iss_cnt_reg   <= '0;
         cap_cnt_reg   <= '0;
         vld_pipe_reg  <= '0;
         res_valid_reg <= 1'b0;
         res_idx_reg   <= '0;
         res_data_reg  <= '0;
         sum_reg       <= '0;
         err_reg       <= 1'b0;
      end else begin
         vld_pipe_reg[0] <= pe_start;
         idx_pipe_reg[0] <= iss_cnt_reg;
         for (int i = 1; i < LATENCY; i++) begin
            vld_pipe_reg[i] <= vld_pipe_reg[i-1];
            idx_pipe_reg[i] <= idx_pipe_reg[i-1];
         end
         if (pe_start) iss_cnt_reg <= iss_cnt_reg + AW'(1);
         res_valid_reg <= capture;
         if (capture) begin
            res_idx_reg  <= idx_pipe_reg[LATENCY-1];
            res_data_reg <= pe_odata;
            sum_reg      <= sum_reg + {{4{pe_odata[15]}}, pe_odata};
            cap_cnt_reg  <= cap_cnt_reg + CW'(1);
            // The PE should already flag done when its first result is taken.
            if (cap_cnt_reg == '0 && !pe_done) err_reg <= 1'b1;
         end
      end
   end

   assign pe_x      = pe_x_reg;
   assign pe_m      = pe_m_reg;
   assign pe_v      = pe_v_reg;
   assign res_valid = res_valid_reg;
   assign res_idx   = res_idx_reg;
   assign res_data  = res_data_reg;
   assign sum_out   = sum_reg;
   assign err       = err_reg;

endmodule

// File: tb/tb_fr_pe_driver.sv
// Bench for fr_pe_driver: behavioural PE plus an array-based reference of the
// operand store and the expected per-cycle run timeline.
module tb_fr_pe_driver;
   localparam int N_IN = 8;
   localparam int AW   = 4;
   localparam int LAT  = 4;

   logic               clk, rst;
   logic               wr_en;
   logic [1:0]         wr_sel;
   logic [AW-1:0]      wr_addr;
   logic signed [15:0] wr_data;
   logic               go;
   logic               busy, pe_rst, pe_start;
   logic signed [15:0] pe_x, pe_m, pe_v;
   logic signed [15:0] pe_odata;
   logic               pe_done;
   logic               res_valid;
   logic [AW-1:0]      res_idx;
   logic signed [15:0] res_data;
   logic signed [19:0] sum_out;
   logic               done, err;

   int n_checks = 0;
   int n_errors = 0;
   int run_no   = 0;
   bit pe_done_tie = 1'b1;

   int mx [N_IN];
   int mm [N_IN];
   int mv [N_IN];

   fr_pe_driver #(.N_IN(N_IN), .AW(AW), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
      .wr_data(wr_data), .go(go), .busy(busy), .pe_rst(pe_rst), .pe_start(pe_start),
      .pe_x(pe_x), .pe_m(pe_m), .pe_v(pe_v), .pe_odata(pe_odata), .pe_done(pe_done),
      .res_valid(res_valid), .res_idx(res_idx), .res_data(res_data),
      .sum_out(sum_out), .done(done), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic longint pe_f(input longint x, input longint m, input longint v);
      longint d, t;
      d = x - m;
      t = (d * d) / 1000;
      return (t * v) / 100;
   endfunction

   // Behavioural PE: fixed LAT-cycle pipeline, junk on the output when not valid.
   logic signed [15:0] pd [LAT];
   logic [LAT-1:0]     pv;
   logic               pe_done_flag;
   always @(posedge clk) begin
      if (rst || pe_rst) begin
         for (int i = 0; i < LAT; i++) pd[i] <= 16'sh5EAD;
         pv           <= '0;
         pe_done_flag <= 1'b0;
      end else begin
         pv[0] <= pe_start;
         pd[0] <= pe_start ? 16'(pe_f(pe_x, pe_m, pe_v)) : 16'sh5EAD;
         for (int i = 1; i < LAT; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
         end
         if (pv[LAT-2]) pe_done_flag <= 1'b1;
      end
   end
   assign pe_odata = pd[LAT-1];
   assign pe_done  = pe_done_tie ? pe_done_flag : 1'b0;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic write_elem(input int sel, input int addr, input int data);
      wr_en   = 1'b1;
      wr_sel  = 2'(sel);
      wr_addr = AW'(addr);
      wr_data = 16'(data);
      if (sel < 3 && addr < N_IN) begin
         if (sel == 0) mx[addr] = int'($signed(16'(data)));
         if (sel == 1) mm[addr] = int'($signed(16'(data)));
         if (sel == 2) mv[addr] = int'($signed(16'(data)));
      end
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // Starts at a negedge; go is sampled on the following rising edge (cycle k=0).
   task automatic run(input int extra_go_k, input bit wr_busy, input bit wr_go,
                      input int wr_go_addr, input int wr_go_data, input int tail);
      longint exp_res [N_IN];
      longint exp_sum;
      int     j;
      run_no++;
      go = 1'b1;
      if (wr_go) begin
         wr_en = 1'b1; wr_sel = 2'd0; wr_addr = AW'(wr_go_addr); wr_data = 16'(wr_go_data);
         mx[wr_go_addr] = int'($signed(16'(wr_go_data)));
      end
      exp_sum = 0;
      for (int i = 0; i < N_IN; i++) begin
         exp_res[i] = longint'($signed(16'(pe_f(mx[i], mm[i], mv[i]))));
         exp_sum += exp_res[i];
      end
      for (int k = 1; k <= N_IN + 6; k++) begin
         @(negedge clk);
         go    = (k == extra_go_k);
         wr_en = wr_busy && (k == 3);
         if (wr_busy && k == 3) begin
            wr_sel = 2'd0; wr_addr = '0; wr_data = 16'sd999;
         end
         check("busy", longint'(busy), 1);
         check("pe_rst", longint'(pe_rst), longint'(k == 1));
         check("pe_start", longint'(pe_start), longint'(k >= 2 && k <= N_IN + 1));
         if (k >= 2 && k <= N_IN + 1) begin
            check("pe_x", longint'(pe_x), longint'(mx[k-2]));
            check("pe_m", longint'(pe_m), longint'(mm[k-2]));
            check("pe_v", longint'(pe_v), longint'(mv[k-2]));
         end
         j = k - (LAT + 3);
         check("res_valid", longint'(res_valid), longint'(j >= 0 && j < N_IN));
         if (j >= 0 && j < N_IN) begin
            check("res_idx", longint'(res_idx), longint'(j));
            check("res_data", longint'(res_data), exp_res[j]);
         end
         check("done", longint'(done), longint'(k == N_IN + 6));
         if (k == 2) check("err_cleared", longint'(err), 0);
         if (k == N_IN + 6) begin
            check("sum_out", longint'(sum_out), exp_sum);
            check("err_final", longint'(err), longint'(!pe_done_tie));
            $display("run %0d: sum_out=%0d expected=%0d err=%0d", run_no, sum_out, exp_sum, err);
         end
      end
      for (int t = 0; t < tail; t++) begin
         @(negedge clk);
         go    = 1'b0;
         wr_en = 1'b0;
         check("idle_busy", longint'(busy), 0);
         check("idle_done", longint'(done), 0);
         check("hold_sum", longint'(sum_out), exp_sum);
      end
      go    = 1'b0;
      wr_en = 1'b0;
   endtask

   task automatic clear_model();
      for (int i = 0; i < N_IN; i++) begin
         mx[i] = 0; mm[i] = 0; mv[i] = 0;
      end
   endtask

   task automatic load_ramp();
      for (int i = 0; i < N_IN; i++) begin
         write_elem(0, i, 10 * i + 50);
         write_elem(1, i, 0);
         write_elem(2, i, 100);
      end
   endtask

   initial begin
      rst = 1'b1; go = 1'b0; wr_en = 1'b0; wr_sel = '0; wr_addr = '0; wr_data = '0;
      clear_model();
      #1;
      check("rst_busy", longint'(busy), 0);
      check("rst_pe_start", longint'(pe_start), 0);
      check("rst_res_valid", longint'(res_valid), 0);
      check("rst_sum", longint'(sum_out), 0);
      check("rst_err", longint'(err), 0);
      @(negedge clk);
      rst = 1'b0;

      // Single nonzero element.
      write_elem(0, 0, 100);
      write_elem(1, 0, 50);
      write_elem(2, 0, 200);
      run(0, 0, 0, 0, 0, 2);

      // Ramp vector.
      load_ramp();
      run(0, 0, 0, 0, 0, 2);

      // Reset in the middle of ISSUE.
      go = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         go = 1'b0;
      end
      rst = 1'b1;
      #1;
      check("mid_rst_busy", longint'(busy), 0);
      check("mid_rst_pe_start", longint'(pe_start), 0);
      check("mid_rst_pe_x", longint'(pe_x), 0);
      check("mid_rst_res_valid", longint'(res_valid), 0);
      check("mid_rst_sum", longint'(sum_out), 0);
      @(negedge clk);
      rst = 1'b0;
      clear_model();
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         check("mid_rst_no_done", longint'(done), 0);
         check("mid_rst_idle", longint'(busy), 0);
      end
      run(0, 0, 0, 0, 0, 2);
      load_ramp();
      run(0, 0, 0, 0, 0, 2);

      // Write during busy dropped; second go in DRAIN ignored.
      run(N_IN + 3, 1, 0, 0, 0, 3);
      run(0, 0, 0, 0, 0, 2);

      // PE never flags done.
      pe_done_tie = 1'b0;
      run(0, 0, 0, 0, 0, 2);
      pe_done_tie = 1'b1;
      run(0, 0, 0, 0, 0, 2);

      // Negative operands.
      write_elem(0, 0, -300);
      write_elem(1, 0, 200);
      write_elem(2, 0, 1000);
      check("neg_model", pe_f(-300, 200, 1000), 2500);
      run(0, 0, 0, 0, 0, 2);

      // go in FIN ignored, go in the following IDLE cycle accepted; go with a write.
      run(N_IN + 6, 0, 0, 0, 0, 1);
      run(0, 0, 1, 5, 777, 1);

      // Randomized writes (including dropped ones) and run options.
      for (int r = 0; r < 6; r++) begin
         for (int w = 0; w < 30; w++) begin
            int sel, addr, data;
            sel  = int'($urandom_range(0, 3));
            addr = int'($urandom_range(0, 15));
            if (sel == 2) data = int'($urandom_range(0, 200)) - 100;
            else          data = int'($urandom_range(0, 4000)) - 2000;
            write_elem(sel, addr, data);
         end
         pe_done_tie = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 2))
            0:       run(0, 0, 0, 0, 0, 2);
            1:       run(N_IN + 3, 1, 0, 0, 0, 2);
            default: run(N_IN + 6, 0, 0, 0, 0, 1);
         endcase
      end
      pe_done_tie = 1'b1;
      run(0, 0, 0, 0, 0, 2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
